// File: rtl/pu_ia_itlb_fa_pkg.sv
// Shared widths, thread-mode encoding and defaults for the PU instruction TLB.
// These mirror the pu.h defines so the TLB can be elaborated on its own.
package pu_ia_itlb_fa_pkg;

    localparam int PU_IC_TAG_W     = 20;
    localparam int PU_TID_W        = 2;
    localparam int PU_ITLB_ENTRIES = 8;
    localparam int PU_TMODE_W      = 2;

    typedef enum logic [PU_TMODE_W-1:0] {
        PU_TMODE_KERNEL = 2'b00,
        PU_TMODE_SUPER  = 2'b01,
        PU_TMODE_USER   = 2'b11
    } pu_tmode_e;

    function automatic logic pu_is_kernel(input logic [PU_TMODE_W-1:0] mode);
        return mode == PU_TMODE_KERNEL;
    endfunction

endpackage

// File: rtl/pu_ia_itlb_entry.sv
// One ITLB entry: storage, hit compare against the fetch tag/thread, and
// write/invalidate handling.
module pu_ia_itlb_entry
    import pu_ia_itlb_fa_pkg::*;
#(
    parameter int TAG_W = PU_IC_TAG_W,
    parameter int TID_W = PU_TID_W
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [TAG_W-1:0] vtag,
    input  logic [TID_W-1:0] tid,
    output logic             hit,
    output logic [TAG_W-1:0] ptag,
    output logic             nc,
    output logic             k,
    input  logic             wr_sel,
    input  logic [TAG_W-1:0] wr_vtag,
    input  logic [TAG_W-1:0] wr_ptag,
    input  logic [TID_W-1:0] wr_tid,
    input  logic             wr_g,
    input  logic             wr_nc,
    input  logic             wr_k,
    input  logic             inv_all,
    input  logic             inv_tid_en,
    input  logic [TID_W-1:0] inv_tid
);

    logic             valid;
    logic [TAG_W-1:0] vtag_q;
    logic [TID_W-1:0] tid_q;
    logic             g_q;

    assign hit = valid && (vtag_q == vtag) && (g_q || (tid_q == tid));

    // A write to this entry wins over any invalidate in the same cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            valid <= 1'b0;
        else if (wr_sel)
            valid <= 1'b1;
        else if (inv_all)
            valid <= 1'b0;
        else if (inv_tid_en && !g_q && (tid_q == inv_tid))
            valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_sel) begin
            vtag_q <= wr_vtag;
            ptag   <= wr_ptag;
            tid_q  <= wr_tid;
            g_q    <= wr_g;
            nc     <= wr_nc;
            k      <= wr_k;
        end
    end

endmodule

// File: rtl/pu_ia_itlb_fa.sv
// Fully associative instruction TLB: one-cycle registered translation with
// thread/global tagging, miss and kernel-protection exceptions.
module pu_ia_itlb_fa
    import pu_ia_itlb_fa_pkg::*;
#(
    parameter int ENTRIES = PU_ITLB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PU_IC_TAG_W,
    parameter int TID_W   = PU_TID_W
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [TID_W-1:0]      tid,
    input  logic [PU_TMODE_W-1:0] tmode,
    input  logic                  on,
    input  logic [TAG_W-1:0]      vtag,
    output logic [TAG_W-1:0]      ptag,
    output logic                  nc,
    output logic                  miss,
    output logic                  prot,
    input  logic                  wr_en,
    input  logic                  wr_auto,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_vtag,
    input  logic [TAG_W-1:0]      wr_ptag,
    input  logic [TID_W-1:0]      wr_tid,
    input  logic                  wr_g,
    input  logic                  wr_nc,
    input  logic                  wr_k,
    input  logic                  inv_all,
    input  logic                  inv_tid_en,
    input  logic [TID_W-1:0]      inv_tid,
    output logic [IDX_W-1:0]      victim
);

    logic [ENTRIES-1:0] e_hit;
    logic [ENTRIES-1:0] e_nc;
    logic [ENTRIES-1:0] e_k;
    logic [TAG_W-1:0]   e_ptag [ENTRIES];
    logic [IDX_W-1:0]   wr_tgt;

    logic               sel_hit;
    logic [TAG_W-1:0]   sel_ptag;
    logic               sel_nc;
    logic               sel_k;

    assign wr_tgt = wr_auto ? victim : wr_idx;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        pu_ia_itlb_entry #(
            .TAG_W (TAG_W),
            .TID_W (TID_W)
        ) u_entry (
            .clk        (clk),
            .rst_       (rst_),
            .vtag       (vtag),
            .tid        (tid),
            .hit        (e_hit[i]),
            .ptag       (e_ptag[i]),
            .nc         (e_nc[i]),
            .k          (e_k[i]),
            .wr_sel     (wr_en && (wr_tgt == IDX_W'(i))),
            .wr_vtag    (wr_vtag),
            .wr_ptag    (wr_ptag),
            .wr_tid     (wr_tid),
            .wr_g       (wr_g),
            .wr_nc      (wr_nc),
            .wr_k       (wr_k),
            .inv_all    (inv_all),
            .inv_tid_en (inv_tid_en),
            .inv_tid    (inv_tid)
        );
    end

    // Scan from the top so the lowest hitting index is the one left selected.
    always_comb begin
        sel_hit  = 1'b0;
        sel_ptag = '0;
        sel_nc   = 1'b0;
        sel_k    = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (e_hit[i]) begin
                sel_hit  = 1'b1;
                sel_ptag = e_ptag[i];
                sel_nc   = e_nc[i];
                sel_k    = e_k[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            victim <= '0;
        else if (wr_en && wr_auto)
            victim <= (victim == IDX_W'(ENTRIES - 1)) ? '0 : victim + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptag <= '0;
            nc   <= 1'b0;
            miss <= 1'b0;
            prot <= 1'b0;
        end else if (on && sel_hit) begin
            ptag <= sel_ptag;
            nc   <= sel_nc;
            miss <= 1'b0;
            prot <= sel_k && !pu_is_kernel(tmode);
        end else begin
            ptag <= vtag;
            nc   <= 1'b0;
            miss <= on;
            prot <= 1'b0;
        end
    end

endmodule
